chip8_reg_mem_xfer: RTL
=======================

Name: chip8_reg_mem_xfer

Overview:
- Sequencer for the CHIP-8 bulk register/memory instructions FX55 (store V0..VX to RAM at I) and FX65 (load V0..VX from RAM at I).
- Drives the 16x8 register file (1-cycle registered read port, 1 write port) and the synchronous main RAM on the CPU's behalf.
- The CPU decode FSM pulses start and stalls until done.

Parameters:
- ADDR_W, 12, RAM address width.
- DATA_W, 8, register and RAM data width.
- IDX_W, 4, register index width (16 registers).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request, sampled only in IDLE
- dir  in  1  0 = store (FX55), 1 = load (FX65); sampled with start
- last_reg  in  IDX_W  X, last register index inclusive; sampled with start
- base_addr  in  ADDR_W  I register value; sampled with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at completion
- rf_rd_sel  out  IDX_W  register-file read select
- rf_rd_data  in  DATA_W  register-file read data, valid the cycle after rf_rd_sel is presented
- rf_we  out  1  register-file write enable
- rf_wr_sel  out  IDX_W  register-file write index
- rf_wr_data  out  DATA_W  register-file write data
- mem_addr  out  ADDR_W  RAM address
- mem_re  out  1  RAM read strobe; data returns the next cycle
- mem_we  out  1  RAM write strobe
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data

Behaviour:
- Reset values: state IDLE, k=0, busy=0, done=0, rf_we=0, mem_re=0, mem_we=0. All select, address and data outputs are 0.
- Outputs are decoded from registered state, k, and the latched inputs. Outputs in a state are held for that whole cycle.
- Latched fields: x, I and dir are captured on the start edge and are stable for the whole operation.
- States: IDLE, S_RDREG, S_WRMEM, L_RDMEM, L_WRREG, DONE.
- IDLE: on start, latch x/I/dir and set k=0. Go to S_RDREG if dir=0, else L_RDMEM.
- S_RDREG: rf_rd_sel=k. Go to S_WRMEM.
- S_WRMEM:
  - mem_we=1, mem_addr=I+k, mem_wdata=rf_rd_data.
  - If k==x go to DONE; else k++ and go to S_RDREG.
- L_RDMEM: mem_re=1, mem_addr=I+k. Go to L_WRREG.
- L_WRREG:
  - rf_we=1, rf_wr_sel=k, rf_wr_data=mem_rdata.
  - If k==x go to DONE; else k++ and go to L_RDMEM.
- DONE: done=1, busy=1. Go to IDLE.
- Latency: start at edge t0, busy rises after t0. Busy lasts 2*(x+1)+1 cycles; the last of these is the done cycle. x=15 gives 33 cycles.
- Address arithmetic is modulo 2^ADDR_W: I=0xFFF, k=1 gives 0x000. No error is flagged.
- start while busy is ignored and not queued.
- mem_we and rf_we are never both high. mem_re and mem_we are never both high.
- Reset mid-operation: go to IDLE within the same edge; no done pulse. Writes already issued stand. The register file is not touched by this block on reset.
- k never exceeds x; the counter does not wrap.

Optional Feature:
- Macro: CHIP8_XFER_I_INC_EN.
- Enabled (COSMAC VIP semantics):
  - Adds output i_upd (1) and output i_next (ADDR_W).
  - In DONE, i_upd=1 and i_next=I+x+1, modulo 2^ADDR_W.
  - Both outputs are 0 in all other states and at reset.
- Disabled: the ports are absent and I is left unchanged (SCHIP semantics). All other timing is identical.

Decomposition:
- Package chip8_pkg:
  - ADDR_W, DATA_W, IDX_W constants.
  - Xfer state enum.
  - XFER_STORE/XFER_LOAD dir encodings.
- No sub-module: the counter and adder are inline.

Test Plan:
- Store, x=0, I=0x300, V0=0xAB: one mem_we at 0x300 with data 0xAB. busy high for 3 cycles, done on the 3rd.
- Store, x=15, I=0x200, Vn=n*0x11: 16 writes to 0x200..0x20F with 0x00..0xFF. done at cycle 33. No rf_we seen.
- Load, x=3, I=0x400, RAM=01,02,03,04: V0..V3 equal 01..04. V4..VF unchanged. No mem_we seen.
- Wrap, store, x=2, I=0xFFE: writes land at 0xFFE, 0xFFF, 0x000.
- start held high during a load with x=5: only one operation runs and exactly one done is produced. A start arriving in the done cycle is ignored; a start in the following IDLE cycle launches a new operation.
- Reset asserted in the 3rd cycle of a store with x=7: after that edge all outputs are at reset values and no done appears. With CHIP8_XFER_I_INC_EN, a complete load with x=4 and I=0x500 gives i_upd=1 and i_next=0x505 for exactly one cycle.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared constants and encodings for the CHIP-8 register/memory transfer sequencer.
package chip8_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int IDX_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    S_RDREG,
    S_WRMEM,
    L_RDMEM,
    L_WRREG,
    DONE
  } xfer_state_t;

  localparam logic XFER_STORE = 1'b0;
  localparam logic XFER_LOAD  = 1'b1;

endpackage

// File: rtl/chip8_reg_mem_xfer.sv
// FX55/FX65 sequencer: 2 cycles per register plus one done cycle; the CPU stalls while busy.
// Optional CHIP8_XFER_I_INC_EN adds i_upd/i_next (I advanced by x+1 in the done cycle).
module chip8_reg_mem_xfer
  import chip8_pkg::*;
#(
  parameter int ADDR_W = chip8_pkg::ADDR_W,
  parameter int DATA_W = chip8_pkg::DATA_W,
  parameter int IDX_W  = chip8_pkg::IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              dir,
  input  logic [IDX_W-1:0]  last_reg,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  rf_rd_sel,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_we,
  output logic [IDX_W-1:0]  rf_wr_sel,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef CHIP8_XFER_I_INC_EN
  ,
  output logic              i_upd,
  output logic [ADDR_W-1:0] i_next
`endif
);

  xfer_state_t       state, state_nxt;
  logic [IDX_W-1:0]  k, k_nxt;
  logic [IDX_W-1:0]  x_q;
  logic [ADDR_W-1:0] i_q;
  logic [ADDR_W-1:0] addr_k;

  // Direction is carried by which branch of the state graph is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      k     <= '0;
      x_q   <= '0;
      i_q   <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      if (state == IDLE && start) begin
        x_q <= last_reg;
        i_q <= base_addr;
      end
    end
  end

  assign addr_k = i_q + ADDR_W'(k);

  always_comb begin
    state_nxt  = state;
    k_nxt      = k;
    busy       = (state != IDLE);
    done       = 1'b0;
    rf_rd_sel  = '0;
    rf_we      = 1'b0;
    rf_wr_sel  = '0;
    rf_wr_data = '0;
    mem_addr   = '0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
`ifdef CHIP8_XFER_I_INC_EN
    i_upd      = 1'b0;
    i_next     = '0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          k_nxt     = '0;
          state_nxt = (dir == XFER_STORE) ? S_RDREG : L_RDMEM;
        end
      end
      S_RDREG: begin
        rf_rd_sel = k;
        state_nxt = S_WRMEM;
      end
      S_WRMEM: begin
        mem_we    = 1'b1;
        mem_addr  = addr_k;
        mem_wdata = rf_rd_data;
        if (k == x_q) begin
          state_nxt = DONE;
        end else begin
          k_nxt     = k + 1'b1;
          state_nxt = S_RDREG;
        end
      end
      L_RDMEM: begin
        mem_re    = 1'b1;
        mem_addr  = addr_k;
        state_nxt = L_WRREG;
      end
      L_WRREG: begin
        rf_we      = 1'b1;
        rf_wr_sel  = k;
        rf_wr_data = mem_rdata;
        if (k == x_q) begin
          state_nxt = DONE;
        end else begin
          k_nxt     = k + 1'b1;
          state_nxt = L_RDMEM;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
`ifdef CHIP8_XFER_I_INC_EN
        i_upd     = 1'b1;
        i_next    = i_q + ADDR_W'(x_q) + ADDR_W'(1);
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
